// File: rtl/cardinal_pkg.sv
// Shared definitions for the Cardinal fetch slice: datapath widths, the
// end-of-program NOP encoding and the instruction memory address window.
// Bit vectors use big-endian numbering: bit 0 is the MSB, bit 31 the LSB.
package cardinal_pkg;

   localparam int PC_W          = 32;
   localparam int INSTR_W       = 32;
   localparam int IMEM_ADDR_LSB = 21;
   localparam int IMEM_ADDR_MSB = 29;

   localparam logic [0:INSTR_W-1] INSTR_NOP = 32'h0000_0000;

   // Word-align a fetch address by clearing the byte-offset bits below the
   // instruction memory word index.
   function automatic logic [0:PC_W-1] alignPc(input logic [0:PC_W-1] addr);
      logic [0:PC_W-1] aligned;
      aligned = addr;
      aligned[IMEM_ADDR_MSB+1:PC_W-1] = '0;
      return aligned;
   endfunction

endpackage

// File: rtl/cardinal_if_id_reg.sv
// IF/ID pipeline register: instruction, its address and a valid flag.
// Control priority is flush > hold > load. A flush turns the slot into a
// bubble (valid=0, instr=0) while keeping the last address for reference.
module cardinal_if_id_reg
   import cardinal_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               hold,
   input  logic               load,
   input  logic [0:INSTR_W-1] instrIn,
   input  logic [0:PC_W-1]    pcIn,
   output logic [0:INSTR_W-1] instr,
   output logic [0:PC_W-1]    pc,
   output logic               valid
);

   // Pipeline slot update: bubble on flush, freeze on hold, capture on load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr <= '0;
         pc    <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         instr <= '0;
         valid <= 1'b0;
      end else if (hold) begin
         instr <= instr;
      end else if (load) begin
         instr <= instrIn;
         pc    <= pcIn;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/cardinal_fetch.sv
// Cardinal instruction fetch stage. Owns the program counter, presents it to
// the combinational instruction memory and captures the returned word into
// the IF/ID register.
// Optional feature: define CARDINAL_FETCH_HALT_EN to freeze fetch after an
// all-zero NOP is fetched (halted becomes a register); otherwise halted is 0.
//
// Flow control: stall is the decode stage's "not ready". On any edge where
// stall=1 the IF/ID slot and pc hold, so a word presented with valid=1 stays
// until an edge with stall=0 consumes it. redirect_en overrides stall and
// replaces the slot with a bubble. All three controls are sampled on posedge
// only; every output is a register.
module cardinal_fetch
   import cardinal_pkg::*;
#(
   parameter logic [0:PC_W-1] RESET_PC = 32'h0000_0000,
   parameter int unsigned     PC_STEP  = 4
) (
   input  logic               clk,
   input  logic               reset,
   output logic [0:PC_W-1]    pc,
   input  logic [0:INSTR_W-1] instr_in,
   input  logic               stall,
   input  logic               redirect_en,
   input  logic [0:PC_W-1]    redirect_pc,
   output logic [0:INSTR_W-1] if_id_instr,
   output logic [0:PC_W-1]    if_id_pc,
   output logic               if_id_valid,
   output logic               halted
);

   logic [0:PC_W-1] pcReg;
   logic            slotFlush;
   logic            slotHold;
   logic            slotLoad;

   assign pc = pcReg;

`ifdef CARDINAL_FETCH_HALT_EN
   logic haltedReg;
   logic nopFetched;

   assign halted     = haltedReg;
   assign nopFetched = (instr_in == INSTR_NOP);

   // PC and halt state: redirect > stall > halted > fetch; a fetched NOP
   // sets halted and leaves pc pointing at it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcReg     <= RESET_PC;
         haltedReg <= 1'b0;
      end else if (redirect_en) begin
         pcReg     <= alignPc(redirect_pc);
         haltedReg <= 1'b0;
      end else if (stall || haltedReg) begin
         pcReg     <= pcReg;
      end else if (nopFetched) begin
         haltedReg <= 1'b1;
      end else begin
         pcReg     <= pcReg + PC_W'(PC_STEP);
      end
   end
`else
   assign halted = 1'b0;

   // PC update: redirect > stall > sequential fetch; addition wraps mod 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcReg <= RESET_PC;
      end else if (redirect_en) begin
         pcReg <= alignPc(redirect_pc);
      end else if (!stall) begin
         pcReg <= pcReg + PC_W'(PC_STEP);
      end
   end
`endif

   // IF/ID slot control derived from the same priority order as the pc.
   always_comb begin
      slotFlush = redirect_en | (!stall & halted);
      slotHold  = !redirect_en & stall;
      slotLoad  = !redirect_en & !stall & !halted;
   end

   cardinal_if_id_reg ifIdReg (
      .clk     (clk),
      .reset   (reset),
      .flush   (slotFlush),
      .hold    (slotHold),
      .load    (slotLoad),
      .instrIn (instr_in),
      .pcIn    (pcReg),
      .instr   (if_id_instr),
      .pc      (if_id_pc),
      .valid   (if_id_valid)
   );

endmodule

// File: tb/tb_cardinal_fetch.sv
// Directed bench for cardinal_fetch. A pattern memory returns pc ^ C0DE0000
// for every address except an optional zero-word location.
module tb_cardinal_fetch;

   logic        clk;
   logic        reset;
   logic [0:31] pcOut;
   logic [0:31] instrIn;
   logic        stall;
   logic        redirectEn;
   logic [0:31] redirectPc;
   logic [0:31] ifIdInstr;
   logic [0:31] ifIdPc;
   logic        ifIdValid;
   logic        halted;

   logic        zeroEn;
   logic [0:31] zeroAddr;

   int total = 0;
   int bad   = 0;

   cardinal_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pcOut),
      .instr_in    (instrIn),
      .stall       (stall),
      .redirect_en (redirectEn),
      .redirect_pc (redirectPc),
      .if_id_instr (ifIdInstr),
      .if_id_pc    (ifIdPc),
      .if_id_valid (ifIdValid),
      .halted      (halted)
   );

   // Clock: 10 time-unit period, first posedge at t=5.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational instruction memory model.
   assign instrIn = (zeroEn && pcOut == zeroAddr) ? 32'h0 : (pcOut ^ 32'hC0DE_0000);

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return addr ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // One clock: cross the active edge, then settle to the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expectSlot(input string tag, input logic [31:0] expPc,
                             input logic [31:0] expInstr, input logic [31:0] expIfPc,
                             input logic expValid, input logic expHalted);
      check({tag, ".pc"}, pcOut, expPc);
      check({tag, ".instr"}, ifIdInstr, expInstr);
      check({tag, ".ifpc"}, ifIdPc, expIfPc);
      check({tag, ".valid"}, {31'b0, ifIdValid}, {31'b0, expValid});
      check({tag, ".halted"}, {31'b0, halted}, {31'b0, expHalted});
   endtask

   // Time bound for the whole run.
   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b0;
      stall      = 1'b0;
      redirectEn = 1'b0;
      redirectPc = 32'h0;
      zeroEn     = 1'b0;
      zeroAddr   = 32'h0;

      #2;
      expectSlot("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

      @(negedge clk);
      reset = 1'b1;
      check("preFetch.pc", pcOut, 32'h0);

      // Sequential fetch.
      step();
      expectSlot("seq1", 32'h4, memWord(32'h0), 32'h0, 1'b1, 1'b0);
      step();
      expectSlot("seq2", 32'h8, memWord(32'h4), 32'h4, 1'b1, 1'b0);

      // Stall held three cycles at pc=8.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         expectSlot($sformatf("stall%0d", i), 32'h8, memWord(32'h4), 32'h4, 1'b1, 1'b0);
      end
      stall = 1'b0;
      step();
      expectSlot("resume", 32'hC, memWord(32'h8), 32'h8, 1'b1, 1'b0);
      step();
      expectSlot("seq5", 32'h10, memWord(32'hC), 32'hC, 1'b1, 1'b0);

      // Redirect with simultaneous stall; low address bits are dropped.
      stall      = 1'b1;
      redirectEn = 1'b1;
      redirectPc = 32'h0000_0103;
      step();
      expectSlot("redir", 32'h100, 32'h0, 32'hC, 1'b0, 1'b0);
      stall      = 1'b0;
      redirectEn = 1'b0;
      step();
      expectSlot("redirTgt", 32'h104, memWord(32'h100), 32'h100, 1'b1, 1'b0);

      // Jump to 16 where memory returns the all-zero word.
      redirectEn = 1'b1;
      redirectPc = 32'h10;
      step();
      expectSlot("toNop", 32'h10, 32'h0, 32'h100, 1'b0, 1'b0);
      redirectEn = 1'b0;
      zeroEn     = 1'b1;
      zeroAddr   = 32'h10;
      step();
`ifdef CARDINAL_FETCH_HALT_EN
      expectSlot("nopFetch", 32'h10, 32'h0, 32'h10, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         step();
         expectSlot($sformatf("halt%0d", i), 32'h10, 32'h0, 32'h10, 1'b0, 1'b1);
      end
      redirectEn = 1'b1;
      redirectPc = 32'h40;
      step();
      expectSlot("unhalt", 32'h40, 32'h0, 32'h10, 1'b0, 1'b0);
      redirectEn = 1'b0;
      zeroEn     = 1'b0;
      step();
      expectSlot("afterHalt", 32'h44, memWord(32'h40), 32'h40, 1'b1, 1'b0);
`else
      expectSlot("nopPass", 32'h14, 32'h0, 32'h10, 1'b1, 1'b0);
      step();
      expectSlot("nopNext", 32'h18, memWord(32'h14), 32'h14, 1'b1, 1'b0);
      zeroEn = 1'b0;
`endif

      // Wrap-around from the top word.
      redirectEn = 1'b1;
      redirectPc = 32'hFFFF_FFFC;
      step();
      check("wrapRedir.pc", pcOut, 32'hFFFF_FFFC);
      check("wrapRedir.valid", {31'b0, ifIdValid}, 32'h0);
      redirectEn = 1'b0;
      step();
      expectSlot("wrap", 32'h0, memWord(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b1, 1'b0);
      step();
      expectSlot("postWrap", 32'h4, memWord(32'h0), 32'h0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a stall.
      stall = 1'b1;
      step();
      expectSlot("preRst", 32'h4, memWord(32'h0), 32'h0, 1'b1, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      expectSlot("asyncRst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      expectSlot("rstHeld", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      reset = 1'b1;
      stall = 1'b0;
      step();
      expectSlot("rstFetch", 32'h4, memWord(32'h0), 32'h0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
